// File: rtl/la_idiff_filter.sv
// Differential pad receiver: synchronizes both legs, accepts a level change only
// after FILTER consistent samples, and qualifies/counts non-differential faults.
module la_idiff_filter #(
    parameter string PROP       = "DEFAULT",
    parameter int    SYNCSTAGES = 2,
    parameter int    FILTER     = 4,
    parameter int    CNTW       = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in,
    input  logic            inb,
    input  logic            en,
    input  logic            clear,
    output logic            z,
    output logic            rise,
    output logic            fall,
    output logic            fault,
    output logic [CNTW-1:0] faultcnt
);
    localparam int            CW       = $clog2(FILTER) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_PEND   = 2'd1,
        ST_CHKF   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SYNCSTAGES-1:0] sp_sync_q, sp_sync_d;
    logic [SYNCSTAGES-1:0] sn_sync_q, sn_sync_d;
    logic                  z_q, z_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  fault_q, fault_d;
    logic [CNTW-1:0]       faultcnt_q, faultcnt_d;
    logic                  fault_inc;
    logic                  sp, sn, diff_ok, cand;

    // PROP is a pass-through tag for implementation selection; no logic depends on it.
    logic prop_unused;
    assign prop_unused = (PROP != "");

    assign sp      = sp_sync_q[SYNCSTAGES-1];
    assign sn      = sn_sync_q[SYNCSTAGES-1];
    assign diff_ok = sp ^ sn;
    assign cand    = sp;

    always_comb begin
        sp_sync_d = {sp_sync_q[SYNCSTAGES-2:0], in};
        sn_sync_d = {sn_sync_q[SYNCSTAGES-2:0], inb};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        fault_d   = fault_q;
        fault_inc = 1'b0;

        if (!en) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (!diff_ok) begin
                        state_d = ST_CHKF;
                        cnt_d   = CW'(1);
                    end else if (cand != z_q) begin
                        state_d = ST_PEND;
                        cnt_d   = CW'(1);
                    end
                end
                ST_PEND: begin
                    if (!diff_ok) begin
                        state_d = ST_CHKF;
                        cnt_d   = CW'(1);
                    end else if (cand == z_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        z_d     = cand;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_CHKF: begin
                    if (diff_ok) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_FAULT;
                        cnt_d     = '0;
                        fault_d   = 1'b1;
                        fault_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_FAULT: begin
                    // In FAULT, cnt tracks consecutive good differential samples.
                    if (!diff_ok) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        rise_d = z_d & ~z_q;
        fall_d = ~z_d & z_q;

        faultcnt_d = faultcnt_q;
        if (clear) begin
            faultcnt_d = '0;
        end else if (fault_inc && (faultcnt_q != {CNTW{1'b1}})) begin
            faultcnt_d = faultcnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sp_sync_q  <= '0;
            sn_sync_q  <= '1;
            state_q    <= ST_STABLE;
            cnt_q      <= '0;
            z_q        <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            fault_q    <= 1'b0;
            faultcnt_q <= '0;
        end else begin
            sp_sync_q  <= sp_sync_d;
            sn_sync_q  <= sn_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            z_q        <= z_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            fault_q    <= fault_d;
            faultcnt_q <= faultcnt_d;
        end
    end

    assign z        = z_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign fault    = fault_q;
    assign faultcnt = faultcnt_q;

endmodule

// File: tb/tb_la_idiff_filter.sv
// Directed bench for la_idiff_filter: reset, latency, glitch rejection,
// fault qualification, counter saturation/clear, enable and mid-change reset.
module tb_la_idiff_filter;
    logic       clk = 1'b0;
    logic       nreset;
    logic       pad_p;
    logic       pad_n;
    logic       en;
    logic       clear;
    logic       z, rise, fall, fault;
    logic [7:0] faultcnt;
    logic       z_w2, rise_w2, fall_w2, fault_w2;
    logic [1:0] faultcnt_w2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    la_idiff_filter #(.SYNCSTAGES(2), .FILTER(4), .CNTW(8)) dut (
        .clk(clk), .nreset(nreset), .in(pad_p), .inb(pad_n), .en(en), .clear(clear),
        .z(z), .rise(rise), .fall(fall), .fault(fault), .faultcnt(faultcnt)
    );

    la_idiff_filter #(.SYNCSTAGES(2), .FILTER(4), .CNTW(2)) dut_w2 (
        .clk(clk), .nreset(nreset), .in(pad_p), .inb(pad_n), .en(en), .clear(clear),
        .z(z_w2), .rise(rise_w2), .fall(fall_w2), .fault(fault_w2), .faultcnt(faultcnt_w2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; en = 1'b1; clear = 1'b0;
        pad_p = 1'b1; pad_n = 1'b0;
        tick(3);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z); end
        n_tests++; if (rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise got=%b exp=0", rise); end
        n_tests++; if (fall !== 1'b0) begin n_fail++; $display("FAIL reset_fall got=%b exp=0", fall); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
        n_tests++; if (faultcnt !== 8'd0) begin n_fail++; $display("FAIL reset_faultcnt got=%0d exp=0", faultcnt); end
        n_tests++; if (faultcnt_w2 !== 2'd0) begin n_fail++; $display("FAIL reset_faultcnt_w2 got=%0d exp=0", faultcnt_w2); end
        pad_p = 1'b0; pad_n = 1'b1;
        nreset = 1'b1;
        tick(2);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL post_reset_z got=%b exp=0", z); end
    endtask

    task automatic test_latency();
        pad_p = 1'b1; pad_n = 1'b0;
        tick(5);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL lat_rise_edge5_z got=%b exp=0", z); end
        tick(1);
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL lat_rise_edge6_z got=%b exp=1", z); end
        n_tests++; if (rise !== 1'b1) begin n_fail++; $display("FAIL lat_rise_pulse got=%b exp=1", rise); end
        tick(1);
        n_tests++; if (rise !== 1'b0) begin n_fail++; $display("FAIL lat_rise_one_cycle got=%b exp=0", rise); end
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL lat_rise_hold_z got=%b exp=1", z); end
        pad_p = 1'b0; pad_n = 1'b1;
        tick(5);
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL lat_fall_edge5_z got=%b exp=1", z); end
        tick(1);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL lat_fall_edge6_z got=%b exp=0", z); end
        n_tests++; if (fall !== 1'b1) begin n_fail++; $display("FAIL lat_fall_pulse got=%b exp=1", fall); end
        tick(1);
        n_tests++; if (fall !== 1'b0) begin n_fail++; $display("FAIL lat_fall_one_cycle got=%b exp=0", fall); end
    endtask

    task automatic test_glitch();
        pad_p = 1'b1; pad_n = 1'b0;
        tick(3);
        pad_p = 1'b0; pad_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_tests++;
            if (z !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_cycle%0d got z/rise/fall=%b%b%b exp=000", i, z, rise, fall);
            end
        end
    endtask

    task automatic test_fault();
        pad_p = 1'b1; pad_n = 1'b1;
        tick(5);
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_edge5 got=%b exp=0", fault); end
        tick(1);
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_edge6 got=%b exp=1", fault); end
        n_tests++; if (faultcnt !== 8'd1) begin n_fail++; $display("FAIL fault_cnt got=%0d exp=1", faultcnt); end
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL fault_z_held got=%b exp=0", z); end
        tick(2);
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_edge8 got=%b exp=1", fault); end
        pad_p = 1'b0; pad_n = 1'b1;
        tick(5);
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_exit_edge5 got=%b exp=1", fault); end
        tick(1);
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_exit_edge6 got=%b exp=0", fault); end
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL fault_exit_z got=%b exp=0", z); end
    endtask

    task automatic test_fault_saturate();
        logic [1:0] exp2;
        logic [7:0] exp8;
        nreset = 1'b0;
        tick(2);
        nreset = 1'b1;
        tick(2);
        for (int ep = 1; ep <= 5; ep++) begin
            exp2 = (ep > 3) ? 2'd3 : 2'(ep);
            exp8 = 8'(ep);
            pad_p = 1'b1; pad_n = 1'b1;
            tick(6);
            n_tests++; if (faultcnt_w2 !== exp2) begin n_fail++; $display("FAIL sat_w2_ep%0d got=%0d exp=%0d", ep, faultcnt_w2, exp2); end
            n_tests++; if (faultcnt !== exp8) begin n_fail++; $display("FAIL sat_w8_ep%0d got=%0d exp=%0d", ep, faultcnt, exp8); end
            tick(2);
            pad_p = 1'b0; pad_n = 1'b1;
            tick(8);
            n_tests++; if (fault_w2 !== 1'b0) begin n_fail++; $display("FAIL sat_exit_ep%0d got=%b exp=0", ep, fault_w2); end
        end
        pad_p = 1'b1; pad_n = 1'b1;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_tests++; if (fault_w2 !== 1'b1) begin n_fail++; $display("FAIL clr_fault_entry got=%b exp=1", fault_w2); end
        n_tests++; if (faultcnt_w2 !== 2'd0) begin n_fail++; $display("FAIL clr_w2 got=%0d exp=0", faultcnt_w2); end
        n_tests++; if (faultcnt !== 8'd0) begin n_fail++; $display("FAIL clr_w8 got=%0d exp=0", faultcnt); end
        tick(1);
        n_tests++; if (faultcnt_w2 !== 2'd0) begin n_fail++; $display("FAIL clr_w2_after got=%0d exp=0", faultcnt_w2); end
        pad_p = 1'b0; pad_n = 1'b1;
        tick(8);
    endtask

    task automatic test_enable_and_reset();
        pad_p = 1'b1; pad_n = 1'b0;
        tick(4);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_tests++;
            if (z !== 1'b0 || rise !== 1'b0) begin
                n_fail++;
                $display("FAIL en_off_cycle%0d got z/rise=%b%b exp=00", i, z, rise);
            end
        end
        en = 1'b1;
        tick(3);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL en_restart_edge3_z got=%b exp=0", z); end
        tick(1);
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL en_restart_edge4_z got=%b exp=1", z); end
        n_tests++; if (rise !== 1'b1) begin n_fail++; $display("FAIL en_restart_rise got=%b exp=1", rise); end
        pad_p = 1'b0; pad_n = 1'b1;
        tick(3);
        n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL rst_pend_z got=%b exp=1", z); end
        nreset = 1'b0;
        tick(1);
        n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pend_z got=%b exp=0", z); end
        n_tests++; if (fall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pend_fall got=%b exp=0", fall); end
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_tests++;
            if (z !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_after_cycle%0d got z/rise/fall=%b%b%b exp=000", i, z, rise, fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_fault();
        test_fault_saturate();
        test_enable_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
